// File: rtl/mem_arbiter.sv
// Byte-serial RAM port shared by instruction fetch and load/store.
// Reads are assembled little-endian and extended; writes go out one byte per cycle.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, len_reg;
    logic [ADDR_W-1:0] base_reg;
    logic              uns_reg, gnt_mem_reg, last_mem_reg;
    logic [31:0]       wdata_reg, asm_reg, if_inst_reg, mem_rdata_reg;

    logic              grant_if, grant_mem;
    logic [2:0]        mem_len, offset;
    logic [31:0]       asm_full, load_ext;

    // On a tie the requester that did not win last time is served.
    assign grant_mem = mem_req && (!if_req || !last_mem_reg);
    assign grant_if  = if_req && !grant_mem;
    assign mem_len   = (mem_size == 2'd0) ? 3'd1 : (mem_size == 2'd1) ? 3'd2 : 3'd4;

    // ram_din carries the byte addressed one cycle earlier, i.e. byte cnt-1.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_asm
            localparam logic [2:0] BYTE_CNT = 3'(gi + 1);
            assign asm_full[8*gi +: 8] = (state_reg == RD && cnt_reg == BYTE_CNT) ?
                                         ram_din : asm_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        case (len_reg)
            3'd1:    load_ext = {{24{!uns_reg && asm_full[7]}}, asm_full[7:0]};
            3'd2:    load_ext = {{16{!uns_reg && asm_full[15]}}, asm_full[15:0]};
            default: load_ext = asm_full;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_mem) begin
                    state_next = mem_we ? WR : RD;
                end else if (grant_if) begin
                    state_next = RD;
                end
            end
            RD:      if (cnt_reg == len_reg) state_next = DONE;
            WR:      if (cnt_reg == len_reg - 3'd1) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Latched operands, byte counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            len_reg       <= '0;
            base_reg      <= '0;
            uns_reg       <= 1'b0;
            gnt_mem_reg   <= 1'b0;
            last_mem_reg  <= 1'b0;
            wdata_reg     <= '0;
            asm_reg       <= '0;
            if_inst_reg   <= '0;
            mem_rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_if || grant_mem) begin
                        cnt_reg      <= '0;
                        asm_reg      <= '0;
                        gnt_mem_reg  <= grant_mem;
                        last_mem_reg <= grant_mem;
                        if (grant_mem) begin
                            base_reg  <= mem_addr;
                            len_reg   <= mem_len;
                            uns_reg   <= mem_unsigned;
                            wdata_reg <= mem_wdata;
                        end else begin
                            base_reg  <= if_addr;
                            len_reg   <= 3'd4;
                            uns_reg   <= 1'b0;
                            wdata_reg <= '0;
                        end
                    end
                end
                RD: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    asm_reg <= asm_full;
                    if (cnt_reg == len_reg) begin
                        if (gnt_mem_reg) begin
                            mem_rdata_reg <= load_ext;
                        end else begin
                            if_inst_reg <= asm_full;
                        end
                    end
                end
                WR:      cnt_reg <= cnt_reg + 3'd1;
                default: ;
            endcase
        end
    end

    // The final read cycle keeps presenting the last byte address.
    assign offset = (cnt_reg == len_reg) ? cnt_reg - 3'd1 : cnt_reg;

    // Output logic
    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_dout = '0;
        if_done  = 1'b0;
        mem_done = 1'b0;
        case (state_reg)
            RD: ram_addr = base_reg + {{(ADDR_W-3){1'b0}}, offset};
            WR: begin
                ram_addr = base_reg + {{(ADDR_W-3){1'b0}}, cnt_reg};
                ram_we   = 1'b1;
                case (cnt_reg[1:0])
                    2'd0:    ram_dout = wdata_reg[7:0];
                    2'd1:    ram_dout = wdata_reg[15:8];
                    2'd2:    ram_dout = wdata_reg[23:16];
                    default: ram_dout = wdata_reg[31:24];
                endcase
            end
            DONE: begin
                if_done  = !gnt_mem_reg;
                mem_done = gnt_mem_reg;
            end
            default: ;
        endcase
    end

    assign if_inst   = if_inst_reg;
    assign mem_rdata = mem_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized single-requester traffic,
// with a byte RAM model and a behavioural memory reference.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = '0;
    logic        mem_unsigned = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } done_t;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] addr;
        logic        we;
        logic [7:0]  dout;
        bit          chk_dout;
        bit          chk_zero;
    } bus_t;

    done_t if_q[$];
    done_t mem_q[$];
    bus_t  bus_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    end_req = 1'b0;
    bit    end_ack = 1'b0;
    logic [7:0] sim_ram [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    logic [31:0] last_load = '0;

    localparam int NINIT = 104;

    function automatic logic [31:0] init_addr(int i);
        if (i < 4)        return 32'h100 + 32'(i);
        else if (i < 8)   return 32'h2000 + 32'(i - 4);
        else if (i < 16)  return 32'(i - 8);
        else if (i < 24)  return 32'hFFFF_FFF8 + 32'(i - 16);
        else if (i < 96)  return 32'h1000 + 32'(i - 24);
        else if (i < 100) return 32'h200 + 32'(i - 96);
        else              return 32'h300 + 32'(i - 100);
    endfunction

    function automatic logic [7:0] init_val(logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h100:       return 8'h13;
            32'h101:       return 8'h05;
            32'h102:       return 8'h00;
            32'h103:       return 8'h00;
            32'h2003:      return 8'h80;
            32'hFFFF_FFFF: return 8'h34;
            32'h0:         return 8'h92;
            default: begin
                h = (a * 32'd73) ^ (a >> 2);
                return h[7:0];
            end
        endcase
    endfunction

    function automatic logic [7:0] ref_byte(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Little-endian load of n bytes with optional two's-complement extension.
    function automatic logic [31:0] ref_load(logic [31:0] a, int n, bit uns);
        longint v;
        logic [63:0] u;
        v = 0;
        for (int i = 0; i < n; i++) begin
            v = v + (longint'(ref_byte(a + 32'(i))) << (8 * i));
        end
        u = 64'(v);
        if (!uns && u[8*n-1]) v = v - (longint'(1) << (8 * n));
        u = 64'(v);
        return u[31:0];
    endfunction

    function automatic int size_bytes(logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic void push_bus(int c, string nm, logic [31:0] a, logic we,
                                     logic [7:0] d, bit cd, bit cz);
        bus_t b;
        b.cyc = c; b.name = nm; b.addr = a; b.we = we; b.dout = d;
        b.chk_dout = cd; b.chk_zero = cz;
        bus_q.push_back(b);
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        return 32'h1000 + 32'($urandom_range(0, 60));
    endfunction

    // RAM model: write on the strobe, read data appears one cycle after the address.
    initial begin
        for (int i = 0; i < NINIT; i++) sim_ram[init_addr(i)] = init_val(init_addr(i));
        forever begin
            @(posedge clk);
            if (ram_we) sim_ram[ram_addr] = ram_dout;
            ram_din <= sim_ram.exists(ram_addr) ? sim_ram[ram_addr] : 8'h00;
        end
    end

    // Monitor: pops scoreboard entries when the DUT signals completion or a bus check is due.
    initial begin
        done_t e;
        bus_t  b;
        int    diffs;
        forever begin
            @(negedge clk);
            if (if_done) begin
                checks++;
                if (if_q.size() == 0) begin
                    errors++;
                    $display("FAIL if_done_unexpected cyc=%0d got pulse required none", cyc);
                end else begin
                    e = if_q.pop_front();
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL if_done_cycle got=%0d required=%0d", cyc, e.cyc);
                    end
                    checks++;
                    if (if_inst !== e.data) begin
                        errors++;
                        $display("FAIL if_inst cyc=%0d got=%h required=%h", cyc, if_inst, e.data);
                    end
                end
            end
            if (mem_done) begin
                checks++;
                if (mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_done_unexpected cyc=%0d got pulse required none", cyc);
                end else begin
                    e = mem_q.pop_front();
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL mem_done_cycle got=%0d required=%0d", cyc, e.cyc);
                    end
                    checks++;
                    if (mem_rdata !== e.data) begin
                        errors++;
                        $display("FAIL mem_rdata cyc=%0d got=%h required=%h", cyc, mem_rdata, e.data);
                    end
                end
            end
            while (bus_q.size() > 0 && bus_q[0].cyc <= cyc) begin
                b = bus_q.pop_front();
                checks++;
                if (b.cyc < cyc) begin
                    errors++;
                    $display("FAIL %s missed cyc=%0d required cyc=%0d", b.name, cyc, b.cyc);
                end else if (ram_addr !== b.addr || ram_we !== b.we ||
                             (b.chk_dout && ram_dout !== b.dout)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got addr=%h we=%b dout=%h required addr=%h we=%b dout=%h",
                             b.name, cyc, ram_addr, ram_we, ram_dout, b.addr, b.we, b.dout);
                end
                if (b.chk_zero) begin
                    checks++;
                    if (if_done !== 1'b0 || mem_done !== 1'b0 || if_inst !== 32'h0 || mem_rdata !== 32'h0) begin
                        errors++;
                        $display("FAIL %s_outputs cyc=%0d got if_done=%b mem_done=%b if_inst=%h mem_rdata=%h required all 0",
                                 b.name, cyc, if_done, mem_done, if_inst, mem_rdata);
                    end
                end
            end
            if (end_req && !end_ack) begin
                checks++;
                if (if_q.size() != 0 || mem_q.size() != 0 || bus_q.size() != 0) begin
                    errors++;
                    $display("FAIL pending_expectations got if=%0d mem=%0d bus=%0d required 0 0 0",
                             if_q.size(), mem_q.size(), bus_q.size());
                end
                diffs = 0;
                foreach (ref_mem[a]) begin
                    if (!sim_ram.exists(a) || sim_ram[a] !== ref_mem[a]) diffs++;
                end
                checks++;
                if (diffs != 0) begin
                    errors++;
                    $display("FAIL ram_contents got %0d differing bytes required 0", diffs);
                end
                end_ack = 1'b1;
            end
        end
    end

    task automatic if_op(input logic [31:0] a, input bit scramble);
        int t0;
        @(posedge clk); #1;
        if_addr = a;
        if_req  = 1'b1;
        t0 = cyc;
        if_q.push_back('{t0 + 6, ref_load(a, 4, 1'b1)});
        $display("cyc %0d: IF fetch addr=%h", t0, a);
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            if (k == 0 && scramble) if_addr = $urandom;
            if (if_done) break;
        end
        if_req = 1'b0;
    endtask

    task automatic mem_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input bit scramble);
        int t0;
        int n;
        logic [31:0] w;
        @(posedge clk); #1;
        mem_we = we; mem_size = size; mem_unsigned = uns; mem_addr = a; mem_wdata = wd;
        mem_req = 1'b1;
        t0 = cyc;
        n  = size_bytes(size);
        if (we) begin
            w = wd;
            for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = w[8*i +: 8];
            mem_q.push_back('{t0 + n + 1, last_load});
        end else begin
            last_load = ref_load(a, n, uns);
            mem_q.push_back('{t0 + n + 2, last_load});
        end
        $display("cyc %0d: MEM %s size=%0d uns=%0d addr=%h wdata=%h", t0, we ? "store" : "load",
                 size, uns, a, wd);
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            if (k == 0 && scramble) begin
                mem_we = ~mem_we; mem_size = 2'($urandom); mem_unsigned = ~mem_unsigned;
                mem_addr = $urandom; mem_wdata = $urandom;
            end
            if (mem_done) break;
        end
        mem_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_load = '0;
    endtask

    initial begin
        int t0;
        logic [31:0] w;
        for (int i = 0; i < NINIT; i++) ref_mem[init_addr(i)] = init_val(init_addr(i));
        push_bus(1, "reset_state", 32'h0, 1'b0, 8'h00, 1'b1, 1'b1);
        push_bus(2, "reset_state", 32'h0, 1'b0, 8'h00, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Fetch of 0x00000513 from 0x100
        t0 = cyc + 1;
        for (int i = 0; i < 4; i++) push_bus(t0 + 1 + i, "fetch_addr", 32'h100 + 32'(i), 1'b0, 8'h00, 1'b0, 1'b0);
        push_bus(t0 + 6, "fetch_done_bus", 32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        if_op(32'h100, 1'b0);

        // LB and LBU of 0x80
        t0 = cyc + 1;
        push_bus(t0 + 1, "lb_addr", 32'h2003, 1'b0, 8'h00, 1'b0, 1'b0);
        mem_op(1'b0, 2'd0, 1'b0, 32'h2003, 32'h0, 1'b0);
        mem_op(1'b0, 2'd0, 1'b1, 32'h2003, 32'h0, 1'b1);

        // SW 0xDEADBEEF at 0x40
        t0 = cyc + 1;
        w  = 32'hDEAD_BEEF;
        push_bus(t0, "sw_idle", 32'h0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push_bus(t0 + 1 + i, "sw_byte", 32'h40 + 32'(i), 1'b1, w[8*i +: 8], 1'b1, 1'b0);
        push_bus(t0 + 5, "sw_done_bus", 32'h0, 1'b0, 8'h00, 1'b1, 1'b0);
        mem_op(1'b1, 2'd2, 1'b0, 32'h40, w, 1'b1);

        // LH across the address wrap
        t0 = cyc + 1;
        push_bus(t0 + 1, "lh_wrap_addr0", 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b0, 1'b0);
        push_bus(t0 + 2, "lh_wrap_addr1", 32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        mem_op(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0);

        // Both requesters held high from reset: MEM, IF, MEM, IF
        pulse_reset();
        t0 = cyc;
        mem_we = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0; mem_addr = 32'h300;
        if_addr = 32'h200;
        mem_req = 1'b1; if_req = 1'b1;
        last_load = ref_load(32'h300, 4, 1'b0);
        mem_q.push_back('{t0 + 6, last_load});
        if_q.push_back('{t0 + 13, ref_load(32'h200, 4, 1'b0)});
        mem_q.push_back('{t0 + 20, last_load});
        if_q.push_back('{t0 + 27, ref_load(32'h200, 4, 1'b0)});
        push_bus(t0 + 1, "tie_first_mem", 32'h300, 1'b0, 8'h00, 1'b0, 1'b0);
        push_bus(t0 + 8, "tie_then_if", 32'h200, 1'b0, 8'h00, 1'b0, 1'b0);
        push_bus(t0 + 15, "tie_again_mem", 32'h300, 1'b0, 8'h00, 1'b0, 1'b0);
        push_bus(t0 + 22, "tie_last_if", 32'h200, 1'b0, 8'h00, 1'b0, 1'b0);
        $display("cyc %0d: tie MEM LW 0x300 vs IF 0x200", t0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (cyc == t0 + 20) mem_req = 1'b0;
            if (cyc >= t0 + 27) break;
        end
        if_req = 1'b0; mem_req = 1'b0;

        // Reset during a store aborts it; the held request is served again afterwards
        @(posedge clk); #1;
        w = 32'h1122_3344;
        mem_we = 1'b1; mem_size = 2'd2; mem_unsigned = 1'b0; mem_addr = 32'h500; mem_wdata = w;
        mem_req = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 4; i++) ref_mem[32'h500 + 32'(i)] = w[8*i +: 8];
        push_bus(t0 + 1, "abort_sw_byte0", 32'h500, 1'b1, 8'h44, 1'b1, 1'b0);
        push_bus(t0 + 3, "abort_idle", 32'h0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push_bus(t0 + 4 + i, "retry_sw_byte", 32'h500 + 32'(i), 1'b1, w[8*i +: 8], 1'b1, 1'b0);
        mem_q.push_back('{t0 + 8, 32'h0});
        $display("cyc %0d: SW 0x500 with reset in cycle %0d", t0, t0 + 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_load = '0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            if (mem_done) break;
        end
        mem_req = 1'b0;

        // Randomized single-requester traffic
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            if ($urandom_range(0, 3) == 0) begin
                if_op(rand_addr(), 1'($urandom_range(0, 1)));
            end else begin
                mem_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       rand_addr(), $urandom, 1'($urandom_range(0, 1)));
            end
        end

        repeat (2) begin
            @(posedge clk); #1;
        end
        end_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
